reg_scoreboard: RTL
===================

// Module: reg_scoreboard
// PURPOSE
//  Parametrised register-hazard scoreboard for the pipelined CPU. Replaces the
//  single-entry WILLWRITE/STARTREG/ENDWRITE/ENDREG interlock between decode and
//  writeback. Tracks any number of in-flight writes per architectural register
//  with per-register counters. Stalls decode on RAW hazards and on counter
//  saturation. Sits between the convert stage (issue) and the writereg stage (retire).
// PARAMETERS
//  AW        4  register address width; NREG = 2**AW registers tracked
//  CW        2  per-register pending counter width; max 2**CW-1 writes in flight per reg
//  NSRC      2  source operands checked per issued instruction
//  ZERO_REG  1  1: register 0 is never tracked (writes/reads of r0 never hazard)
// PORTS
//  CLK          in   1         system clock, all state on rising edge
//  RST          in   1         asynchronous active-high reset
//  ISSUE_VALID  in   1         decode presents an instruction this cycle
//  ISSUE_WEN    in   1         instruction will write a register
//  ISSUE_DST    in   AW        destination register
//  ISSUE_SRC    in   NSRC*AW   source registers, src i at [i*AW +: AW]
//  ISSUE_USE    in   NSRC      src i is actually read
//  RETIRE_VALID in   1         writeback commits a register write this cycle
//  RETIRE_DST   in   AW        register being committed
//  FLUSH        in   1         pipeline squash; discard all pending state
//  STALL        out  1         combinational; decode must hold, issue not accepted
//  PENDING      out  2**AW     registered; bit r = count[r] != 0
//  OUTSTANDING  out  AW+CW     registered; total writes in flight
//  BUSY         out  1         registered; OUTSTANDING != 0
//  ERR          out  1         registered, sticky; retire to a zero-count register seen
// BEHAVIOUR
//  - Reset (async, RST=1): every count = 0, PENDING = 0, OUTSTANDING = 0,
//    BUSY = 0, ERR = 0. Reset mid-operation discards all in-flight state immediately.
//  - STALL = ISSUE_VALID & (raw | sat).
//    - raw: any i with ISSUE_USE[i] and count[src_i] != 0, excluding r0 when ZERO_REG.
//    - sat: ISSUE_WEN and count[dst] == 2**CW-1.
//    - STALL is also asserted while FLUSH=1 and ISSUE_VALID=1.
//    - No forwarding bypass: a retire in cycle N does not clear raw until cycle N+1.
//  - Accept = ISSUE_VALID & ~STALL & ISSUE_WEN & ~(ZERO_REG & dst==0).
//    On accept, count[dst] increments at the next edge.
//  - Retire = RETIRE_VALID & ~(ZERO_REG & RETIRE_DST==0).
//    - If count[RETIRE_DST] != 0, it decrements.
//    - If count[RETIRE_DST] == 0, the count is unchanged and ERR is set (sticky until RST).
//  - Simultaneous accept and retire on the same register: net count unchanged;
//    OUTSTANDING unchanged. On different registers, each is applied independently.
//  - OUTSTANDING tracks the sum of counts: +1 on accept, -1 on valid decrement.
//    It never wraps; its width covers NREG*(2**CW-1).
//  - FLUSH (sync) has priority over accept and retire in the same cycle.
//    All counts, PENDING, OUTSTANDING and BUSY go to 0 at the next edge; ERR is kept.
//  - PENDING, BUSY and OUTSTANDING reflect state after the edge (1-cycle latency
//    from accept/retire). STALL uses current counts (0-cycle, combinational).
//  - No counter ever wraps: saturation is prevented by sat; underflow by the ERR rule.
// TESTING
//  1 RST pulse mid-run with count[3]=2 -> async clear: PENDING=0, OUTSTANDING=0,
//    ERR=0, STALL=0.
//  2 Issue WEN dst=5; next cycle issue src0=5 USE=01 -> STALL=1.
//    Retire 5 -> STALL=0 one cycle after the retire edge.
//  3 Issue three writes to r7 (CW=2) -> 4th write to r7 STALL=1, OUTSTANDING=3;
//    one retire r7 -> 4th accepted.
//  4 count[4]=1, same-cycle accept dst=4 and retire 4 -> count[4]=1, PENDING[4]=1,
//    OUTSTANDING unchanged.
//  5 Retire r9 with count[9]=0 -> ERR=1, counts unchanged;
//    ERR stays 1 through FLUSH, clears only on RST.
//  6 OUTSTANDING=5, FLUSH with ISSUE_VALID+WEN dst=2 and retire r1 -> next cycle
//    all counts 0, BUSY=0; issue of dst=2 dropped, STALL=1 during flush.
//    ZERO_REG=1: issue dst=0 / src=0 -> never pending, never STALL.

Source files
------------

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - per-register pending-write scoreboard with RAW/saturation stall
module reg_scoreboard #(
  parameter int AW       = 4,
  parameter int CW       = 2,
  parameter int NSRC     = 2,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 ISSUE_VALID,
  input  logic                 ISSUE_WEN,
  input  logic [AW-1:0]        ISSUE_DST,
  input  logic [NSRC*AW-1:0]   ISSUE_SRC,
  input  logic [NSRC-1:0]      ISSUE_USE,
  input  logic                 RETIRE_VALID,
  input  logic [AW-1:0]        RETIRE_DST,
  input  logic                 FLUSH,
  output logic                 STALL,
  output logic [(1<<AW)-1:0]   PENDING,
  output logic [AW+CW-1:0]     OUTSTANDING,
  output logic                 BUSY,
  output logic                 ERR
);

  localparam int NREG = 1 << AW;
  localparam int OW   = AW + CW;
  localparam logic [CW-1:0] CMAX = '1;
  localparam logic [CW-1:0] C1   = CW'(1);
  localparam logic [OW-1:0] O1   = OW'(1);

  logic [CW-1:0]   cnt   [NREG];
  logic [CW-1:0]   cnt_n [NREG];
  logic [NREG-1:0] pend_n;
  logic [OW-1:0]   out_n;
  logic            raw;
  logic            sat;
  logic            dst_zero;
  logic            ret_zero;
  logic            accept;
  logic            retire_ok;
  logic            dec;
  logic            err_set;

  // RAW check: any used source with a nonzero pending count (r0 exempt when untracked)
  always_comb begin
    raw = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (ISSUE_USE[i] && (cnt[ISSUE_SRC[i*AW +: AW]] != '0) &&
          !(ZERO_REG && (ISSUE_SRC[i*AW +: AW] == '0)))
        raw = 1'b1;
    end
  end

  // Stall, accept and retire qualification; flush squashes both issue and retire
  always_comb begin
    dst_zero  = ZERO_REG && (ISSUE_DST == '0);
    ret_zero  = ZERO_REG && (RETIRE_DST == '0);
    sat       = ISSUE_WEN && (cnt[ISSUE_DST] == CMAX);
    STALL     = ISSUE_VALID & (raw | sat | FLUSH);
    accept    = ISSUE_VALID & ~STALL & ISSUE_WEN & ~dst_zero;
    retire_ok = RETIRE_VALID & ~ret_zero & ~FLUSH;
    dec       = retire_ok & (cnt[RETIRE_DST] != '0);
    err_set   = retire_ok & (cnt[RETIRE_DST] == '0);
  end

  // Next-state counts: an accept and a decrement on the same register cancel out
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      cnt_n[r] = cnt[r];
      if (accept && (ISSUE_DST == AW'(r)) && !(dec && (RETIRE_DST == AW'(r))))
        cnt_n[r] = cnt[r] + C1;
      else if (dec && (RETIRE_DST == AW'(r)) && !(accept && (ISSUE_DST == AW'(r))))
        cnt_n[r] = cnt[r] - C1;
      pend_n[r] = (cnt_n[r] != '0);
    end
  end

  // Running total of in-flight writes, moved by accepts and real decrements only
  always_comb begin
    out_n = OUTSTANDING;
    if (accept && !dec)
      out_n = OUTSTANDING + O1;
    else if (dec && !accept)
      out_n = OUTSTANDING - O1;
  end

  // State update: reset clears everything, flush clears all but the sticky error
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
      PENDING     <= '0;
      OUTSTANDING <= '0;
      BUSY        <= 1'b0;
      ERR         <= 1'b0;
    end else if (FLUSH) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
      PENDING     <= '0;
      OUTSTANDING <= '0;
      BUSY        <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) cnt[r] <= cnt_n[r];
      PENDING     <= pend_n;
      OUTSTANDING <= out_n;
      BUSY        <= (out_n != '0);
      if (err_set)
        ERR <= 1'b1;
    end
  end

endmodule
